aca_correct: RTL and testbench

Variable-latency error-recovery stage for the windowed almost-correct adder (ACA). It accepts operands, forms the per-window group generate/propagate and the one-window-lookahead speculative sum, and detects when speculation failed. On failure it walks the exact carry chain one window per cycle and repairs the affected windows. Result, exact carry-out and an error flag are returned over a valid/ready handshake. It sits downstream of operand registers in the approximate adder datapath and is the consumer of the group signals produced by the team's group-generate cells.

---
 rtl/aca_correct_pkg.sv | 19 +
 rtl/aca_window_gp.sv | 22 ++
 rtl/aca_correct.sv | 137 +++++++++++++
 tb/tb_aca_correct.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aca_correct_pkg.sv
// Shared definitions for the almost-correct adder recovery stage:
// FSM state encoding plus window-count derivation and parameter legality.
package aca_correct_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIX,
    DONE
  } state_t;

  function automatic int aca_nwin(input int width, input int window);
    return width / window;
  endfunction

  function automatic bit aca_params_legal(input int width, input int window);
    return (window > 0) && ((width % window) == 0) && ((width / window) >= 2);
  endfunction

endpackage

// File: rtl/aca_window_gp.sv
// One adder window: group generate/propagate and the window sum for a given
// carry-in.
module aca_window_gp #(
  parameter int WINDOW = 4
) (
  input  logic [WINDOW-1:0] a,
  input  logic [WINDOW-1:0] b,
  input  logic              cin,
  output logic              gg,
  output logic              gp,
  output logic [WINDOW-1:0] sum
);

  logic [WINDOW:0] raw;

  // Group generate is the window's own carry-out with a zero carry-in.
  assign raw = {1'b0, a} + {1'b0, b};
  assign gg  = raw[WINDOW];
  assign gp  = &(a ^ b);
  assign sum = a + b + WINDOW'(cin);

endmodule

// File: rtl/aca_correct.sv
// Variable-latency recovery stage for the windowed almost-correct adder:
// speculative sum in one cycle, exact carry walk one window per cycle on error.
module aca_correct
  import aca_correct_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err_det
);

  localparam int NWIN = aca_nwin(WIDTH, WINDOW);
  localparam int IW   = $clog2(NWIN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWIN - 1);

  if (!aca_params_legal(WIDTH, WINDOW)) begin : g_param_check
    $error("aca_correct: WIDTH must be a multiple of WINDOW with at least two windows");
  end

  logic [NWIN-1:0]              gg, gp, c_spec;
  logic [NWIN-1:0][WINDOW-1:0]  spec_sum;
  logic                         spec_err, spec_cout;

  state_t                       state_q, state_d;
  logic [NWIN-1:0][WINDOW-1:0]  sum_q, sum_d;
  logic [NWIN-1:0]              gg_q, gg_d, gp_q, gp_d, cspec_q, cspec_d;
  logic                         carry_q, carry_d, cout_q, cout_d, err_q, err_d;
  logic [IW-1:0]                idx_q, idx_d, prev_idx;
  logic                         fix_carry;

  // Speculation: each window takes the previous window's generate as carry-in.
  assign c_spec = {gg[NWIN-2:0], cin};

  for (genvar i = 0; i < NWIN; i++) begin : g_win
    aca_window_gp #(.WINDOW(WINDOW)) u_win (
      .a   (a[i*WINDOW +: WINDOW]),
      .b   (b[i*WINDOW +: WINDOW]),
      .cin (c_spec[i]),
      .gg  (gg[i]),
      .gp  (gp[i]),
      .sum (spec_sum[i])
    );
  end

  // A propagating window fed by a live speculative carry is the first miss.
  assign spec_err  = |(gp[NWIN-2:0] & c_spec[NWIN-2:0]);
  assign spec_cout = gg[NWIN-1] | (gp[NWIN-1] & c_spec[NWIN-1]);

  assign prev_idx  = idx_q - IW'(1);
  assign fix_carry = gg_q[prev_idx] | (gp_q[prev_idx] & carry_q);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    gg_d    = gg_q;
    gp_d    = gp_q;
    cspec_d = cspec_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d   = spec_sum;
          gg_d    = gg;
          gp_d    = gp;
          cspec_d = c_spec;
          carry_d = cin;
          idx_d   = IW'(1);
          cout_d  = spec_cout;
          err_d   = spec_err;
          state_d = spec_err ? FIX : DONE;
        end
      end
      FIX: begin
        if (fix_carry && !cspec_q[idx_q]) begin
          sum_d[idx_q] = sum_q[idx_q] + WINDOW'(1);
        end
        carry_d = fix_carry;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = gg_q[NWIN-1] | (gp_q[NWIN-1] & fix_carry);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      gg_q    <= '0;
      gp_q    <= '0;
      cspec_q <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      gg_q    <= gg_d;
      gp_q    <= gp_d;
      cspec_q <= cspec_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err_det   = err_q;

endmodule

// File: tb/tb_aca_correct.sv
// Directed vector bench for aca_correct: latency, results, backpressure and
// asynchronous reset in the middle of a correction walk.
module tb_aca_correct;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        err_det;

  int n_cmp;
  int n_fail;
  int lat;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  aca_correct #(.WIDTH(16), .WINDOW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err_det   (err_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Waits for IDLE, presents one operand set, and measures edges to out_valid
  // counting the accepting edge as the first.
  task automatic applyStimulus(input logic [15:0] a_v, input logic [15:0] b_v, input logic cin_v);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a        = a_v;
    b        = b_v;
    cin      = cin_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, 4};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 4};
    vecs[3] = '{16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
    vecs[4] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b1, 4};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1};
    vecs[7] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b1, 4};

    #12;
    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sum",       {16'd0, sum},       32'd0);
    checkOutput("rst_cout",      {31'd0, cout},      32'd0);
    checkOutput("rst_err",       {31'd0, err_det},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
      checkOutput($sformatf("v%0d_latency", i), lat,                         vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_sum", i),     {16'd0, sum},                {16'd0, vecs[i].exp_sum});
      checkOutput($sformatf("v%0d_cout", i),    {31'd0, cout},               {31'd0, vecs[i].exp_cout});
      checkOutput($sformatf("v%0d_err", i),     {31'd0, err_det},            {31'd0, vecs[i].exp_err});
      checkOutput($sformatf("v%0d_in_ready", i), {31'd0, in_ready},          32'd0);
      releaseResult();
      checkOutput($sformatf("v%0d_idle", i),    {30'd0, out_valid, in_ready}, 32'd1);
    end

    // Backpressure: result held for five cycles while stray in_valid pulses arrive.
    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    checkOutput("bp_latency", lat, 4);
    for (int k = 0; k < 5; k++) begin
      a        = 16'hAAAA;
      b        = 16'h5555;
      cin      = 1'b1;
      in_valid = (k % 2) == 0;
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp%0d_in_ready", k),  {31'd0, in_ready},  32'd0);
      checkOutput($sformatf("bp%0d_sum", k),       {16'd0, sum},       32'h0100);
      checkOutput($sformatf("bp%0d_cout", k),      {31'd0, cout},      32'd0);
      checkOutput($sformatf("bp%0d_err", k),       {31'd0, err_det},   32'd1);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("bp_return_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("bp_return_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_no_stray_accept", {31'd0, out_valid}, 32'd0);

    // Reset asserted during the second correction cycle.
    a        = 16'hFFFF;
    b        = 16'h0000;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("mid_fix_busy", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_sum",       {16'd0, sum},       32'd0);
    checkOutput("mid_rst_err",       {31'd0, err_det},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h1234, 16'h4321, 1'b0);
    checkOutput("post_rst_latency", lat, 1);
    checkOutput("post_rst_sum",  {16'd0, sum},     32'h5555);
    checkOutput("post_rst_cout", {31'd0, cout},    32'd0);
    checkOutput("post_rst_err",  {31'd0, err_det}, 32'd0);
    releaseResult();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
